// File: rtl/if_stage.sv
// Instruction fetch: one-outstanding imem request/response port feeding a 2-entry {inst,pc} buffer to ID.
// Optional macro IF_MISALIGN_TRAP_EN: misaligned redirect targets raise id_misalign and halt fetching.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        arst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
`ifdef IF_MISALIGN_TRAP_EN
    ,
    output logic        id_misalign
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, KILL} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] addr_q;
    logic        req_q;
    logic        kill_pend_q;
    logic [1:0]  count_q;
    logic        rd_ptr_q;
    logic        wr_ptr_q;
    logic [31:0] fifo_inst_q [2];
    logic [31:0] fifo_pc_q   [2];

    logic        trap_q;
    logic        trap_d;
    logic [31:0] trap_pc_q;
    logic        redir_mis;

    logic [31:0] target;
    logic        head_valid;
    logic        push;
    logic        pop;
    logic [1:0]  count_d;
    logic        room;
    logic        fetch_ok;

    assign target = {redirect_pc[31:2], 2'b00};

`ifdef IF_MISALIGN_TRAP_EN
    assign redir_mis = redirect_en && (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            trap_q    <= 1'b0;
            trap_pc_q <= '0;
        end else if (redirect_en) begin
            trap_q    <= redir_mis;
            trap_pc_q <= redirect_pc;
        end
    end

    assign id_misalign = trap_q;
`else
    logic redirect_lsb_unused;
    assign redirect_lsb_unused = ^redirect_pc[1:0];
    assign redir_mis = 1'b0;
    assign trap_q    = 1'b0;
    assign trap_pc_q = '0;
`endif

    assign trap_d     = redirect_en ? redir_mis : trap_q;
    assign fetch_ok   = !trap_d;
    assign head_valid = (count_q != 2'd0);

    // Redirect wins over both ends of the buffer; a response arriving with it belongs to the old path.
    assign push    = (state_q == WAIT) && imem_rvalid && !redirect_en;
    assign pop     = head_valid && id_ready && !redirect_en;
    assign count_d = redirect_en ? 2'd0 : (count_q + {1'b0, push} - {1'b0, pop});
    // Evaluated where nothing is outstanding next cycle, so buffer occupancy alone decides.
    assign room    = (count_d < 2'd2);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            req_q       <= 1'b0;
            kill_pend_q <= 1'b0;
            count_q     <= 2'd0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            if (redirect_en) begin
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
            end else begin
                if (push) wr_ptr_q <= ~wr_ptr_q;
                if (pop)  rd_ptr_q <= ~rd_ptr_q;
            end

            case (state_q)
                IDLE: begin
                    if (redirect_en) begin
                        pc_q <= target;
                        if (fetch_ok) begin
                            state_q <= REQ;
                            req_q   <= 1'b1;
                            addr_q  <= target;
                        end
                    end else if (fetch_ok && room) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        addr_q  <= pc_q;
                    end
                end
                REQ: begin
                    if (imem_gnt) begin
                        req_q       <= 1'b0;
                        kill_pend_q <= 1'b0;
                        if (redirect_en) begin
                            state_q <= KILL;
                            pc_q    <= target;
                        end else if (kill_pend_q) begin
                            state_q <= KILL;
                        end else begin
                            state_q <= WAIT;
                            pc_q    <= pc_q + 32'd4;
                        end
                    end else if (redirect_en) begin
                        // The request must stay stable until granted; its data is dropped later.
                        kill_pend_q <= 1'b1;
                        pc_q        <= target;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (redirect_en) pc_q <= target;
                        if (fetch_ok && room) begin
                            state_q <= REQ;
                            req_q   <= 1'b1;
                            addr_q  <= redirect_en ? target : pc_q;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (redirect_en) begin
                        state_q <= KILL;
                        pc_q    <= target;
                    end
                end
                KILL: begin
                    if (redirect_en) pc_q <= target;
                    if (imem_rvalid) begin
                        if (fetch_ok) begin
                            state_q <= REQ;
                            req_q   <= 1'b1;
                            addr_q  <= redirect_en ? target : pc_q;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    // addr_q still holds the granted address while the response is awaited.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst_q[wr_ptr_q] <= imem_rdata;
            fifo_pc_q[wr_ptr_q]   <= addr_q;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;

    always_comb begin
        id_valid = head_valid;
        id_inst  = head_valid ? fifo_inst_q[rd_ptr_q] : NOP_INST;
        id_pc    = head_valid ? fifo_pc_q[rd_ptr_q] : 32'h0;
        if (trap_q) begin
            id_valid = 1'b1;
            id_inst  = NOP_INST;
            id_pc    = trap_pc_q;
        end
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013, instruction driven to ID when no valid instruction is available.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 arst_n  input  1  asynchronous active-low reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  fetch address, word aligned.
REQ-007 imem_gnt  input  1  request accepted this cycle.
REQ-008 imem_rvalid  input  1  response data valid, in request order.
REQ-009 imem_rdata  input  32  fetched instruction.
REQ-010 redirect_en  input  1  control-flow change from EX (branch/jump taken).
REQ-011 redirect_pc  input  32  new fetch target.
REQ-012 id_ready  input  1  ID accepts id_inst this cycle; low = stall.
REQ-013 id_valid  output  1  id_inst/id_pc hold a real instruction.
REQ-014 id_inst  output  32  instruction to decode (id_stage_in_t.inst).
REQ-015 id_pc  output  32  address of id_inst.
REQ-016 id_misalign  output  1  misaligned redirect flag (present only with IF_MISALIGN_TRAP_EN).

Function
REQ-017 The FSM SHALL have states IDLE, REQ, WAIT and KILL.
REQ-018 The PC register SHALL increment by 4 on every grant; it wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-019 A 2-entry FIFO SHALL hold {inst, pc}; a new request SHALL issue only if fifo_count + outstanding < 2.
REQ-020 IDLE -> REQ when there is FIFO room; REQ holds imem_req=1 with imem_addr stable until imem_gnt; REQ -> WAIT on gnt; WAIT -> REQ (room) or IDLE (no room) on imem_rvalid.
REQ-021 At most one request SHALL be outstanding.
REQ-022 A response in WAIT SHALL be written to the FIFO; id_valid SHALL rise the cycle after imem_rvalid (registered output, latency 1).
REQ-023 id_valid/id_inst/id_pc SHALL show the FIFO head; the head pops when id_valid && id_ready.
REQ-024 With id_ready low, outputs SHALL hold stable; fetching stops when the FIFO plus the outstanding request total 2.
REQ-025 Simultaneous push and pop at count 2 SHALL NOT occur (guaranteed by REQ-019); push and pop at count 1 keep count 1.
REQ-026 redirect_en SHALL flush the FIFO (id_valid=0 next cycle) and load PC <= {redirect_pc[31:2],2'b00}.
REQ-027 Redirect in WAIT SHALL go to KILL; a redirect in REQ SHALL keep req/addr until gnt, then go to KILL; KILL discards the next rvalid and then goes to REQ.
REQ-028 Redirect in IDLE SHALL go to REQ at the new PC next cycle.
REQ-029 Redirect has priority over push and pop in the same cycle; the concurrent response is discarded.
REQ-030 When id_valid=0, id_inst SHALL equal NOP_INST.

Reset
REQ-031 On arst_n low, immediately: state=IDLE, PC=RESET_PC, FIFO empty, outstanding=0, imem_req=0, imem_addr=RESET_PC, id_valid=0, id_inst=NOP_INST, id_pc=0, id_misalign=0.
REQ-032 Reset asserted mid-transaction SHALL abandon the outstanding request; responses after reset release with no request outstanding SHALL be ignored.
REQ-033 The first imem_req SHALL assert one cycle after arst_n deasserts (IDLE -> REQ).

Configuration
REQ-034 With macro IF_MISALIGN_TRAP_EN defined, a redirect with redirect_pc[1:0]!=0 SHALL set id_misalign=1 and id_valid=1 with id_pc=redirect_pc and id_inst=NOP_INST, suppress fetching until redirect_en arrives with an aligned target, and clear the flag on that redirect.
REQ-035 Without IF_MISALIGN_TRAP_EN, port id_misalign SHALL be absent, and redirect_pc[1:0] SHALL be silently ignored.

Verification
REQ-036 Reset release, gnt immediate, rvalid 1 cycle later, rdata 32'h00500093 -> imem_addr 0,4,8...; id_valid at cycle 3 with id_inst 32'h00500093, id_pc 0.
REQ-037 id_ready=0 for 10 cycles -> no more than 2 instructions buffered, imem_req low afterward, id outputs constant; release -> PCs 0,4,8 in order with no gaps or duplicates.
REQ-038 redirect_en with redirect_pc 32'h100 while in WAIT -> stale response dropped; next id_pc=32'h100; id_valid low for 1 or more cycles.
REQ-039 PC 32'hFFFF_FFFC granted -> next imem_addr 32'h0000_0000.
REQ-040 Macro on, redirect_pc 32'h102 -> id_misalign=1, id_pc=32'h102, no imem_req until redirect to 32'h200.
REQ-041 arst_n pulsed low in WAIT, rvalid arrives after release -> ignored; fetch restarts at RESET_PC.
